store_queue_unit: RTL and testbench

// - Parametrised store unit: accepts store ops from the decode unit and computes address/strobe/data.
// - Buffers stores in a DEPTH-entry FIFO and issues them on AXI4-Lite AW/W with independent channel progress.
// - Tracks B responses; reports errors and an idle flag for fence/drain logic.
// - Sits between the decode unit and the data-memory AXI4-Lite write port.

---
 rtl/store_queue_unit_if.sv | 43 ++++
 rtl/store_queue_unit.sv | 153 +++++++++++++++
 tb/tb_store_queue_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_queue_unit_if.sv
// Store unit handshake bundle: decode-side request channel plus the AXI4-Lite write port.
// master = store unit side, slave = decode unit / memory side.
interface store_queue_unit_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned STRB = XLEN / 8;

  logic            o_dm_awvalid;
  logic            i_dm_awready;
  logic [XLEN-1:0] o_dm_awaddr;
  logic [2:0]      o_dm_awprot;
  logic            o_dm_wvalid;
  logic            i_dm_wready;
  logic [XLEN-1:0] o_dm_wdata;
  logic [STRB-1:0] o_dm_wstrb;
  logic            i_dm_bvalid;
  logic            o_dm_bready;
  logic [1:0]      i_dm_bresp;

  logic            i_du_valid;
  logic            o_su_ready;
  logic [6:0]      i_du_opcode;
  logic [2:0]      i_du_funct3;
  logic [XLEN-1:0] i_du_immediate;
  logic [XLEN-1:0] i_du_rf_rs1_rdata;
  logic [XLEN-1:0] i_du_rf_rs2_rdata;

  modport master (
    output o_dm_awvalid, o_dm_awaddr, o_dm_awprot, o_dm_wvalid, o_dm_wdata, o_dm_wstrb,
    output o_dm_bready, o_su_ready,
    input  i_dm_awready, i_dm_wready, i_dm_bvalid, i_dm_bresp,
    input  i_du_valid, i_du_opcode, i_du_funct3, i_du_immediate,
    input  i_du_rf_rs1_rdata, i_du_rf_rs2_rdata
  );

  modport slave (
    input  o_dm_awvalid, o_dm_awaddr, o_dm_awprot, o_dm_wvalid, o_dm_wdata, o_dm_wstrb,
    input  o_dm_bready, o_su_ready,
    output i_dm_awready, i_dm_wready, i_dm_bvalid, i_dm_bresp,
    output i_du_valid, i_du_opcode, i_du_funct3, i_du_immediate,
    output i_du_rf_rs1_rdata, i_du_rf_rs2_rdata
  );
endinterface

// File: rtl/store_queue_unit.sv
// Store unit: decodes stores, queues them in a DEPTH-entry FIFO, issues AXI4-Lite AW/W, tracks B.
// Optional STORE_UNIT_MISALIGN_TRAP_EN: misaligned stores are trapped instead of issued.
module store_queue_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  store_queue_unit_if.master bus,
  output logic               o_su_idle,
  output logic               o_su_err
`ifdef STORE_UNIT_MISALIGN_TRAP_EN
  ,
  output logic               o_su_misalign
`endif
);
  localparam int unsigned STRB = XLEN / 8;
  localparam int unsigned OFFW = $clog2(STRB);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [6:0]    OP_STORE = 7'b0100011;
`ifdef STORE_UNIT_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [XLEN-1:0] mem_addr [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [STRB-1:0] mem_strb [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, outstanding;
  logic            aw_done, w_done, err_q;

  logic [XLEN-1:0] rs2, req_addr, req_data;
  logic [OFFW-1:0] req_off;
  logic [STRB-1:0] req_strb;
  logic            req_f3_ok, req_misaligned;
  logic            accept, is_store, enq, head_valid, aw_fire, w_fire, pop, b_fire, b_dec;

  assign rs2      = bus.i_du_rf_rs2_rdata;
  assign req_addr = bus.i_du_rf_rs1_rdata + bus.i_du_immediate;
  assign req_off  = req_addr[OFFW-1:0];

  // Data is replicated across lanes, so only the strobe depends on the byte offset.
  always_comb begin
    req_data       = '0;
    req_strb       = '0;
    req_f3_ok      = 1'b1;
    req_misaligned = 1'b0;
    case (bus.i_du_funct3)
      3'b000: begin
        req_data = {STRB{rs2[7:0]}};
        req_strb = STRB'(1) << req_off;
      end
      3'b001: begin
        req_data       = {(STRB/2){rs2[15:0]}};
        req_strb       = STRB'(2'b11) << req_off;
        req_misaligned = req_off[0];
      end
      3'b010: begin
        req_data       = {(XLEN/32){rs2[31:0]}};
        req_strb       = STRB'(4'hF) << req_off;
        req_misaligned = |req_off[1:0];
      end
      3'b011: begin
        if (XLEN == 64) begin
          req_data       = rs2;
          req_strb       = '1;
          req_misaligned = |req_off;
        end else begin
          req_f3_ok = 1'b0;
        end
      end
      default: req_f3_ok = 1'b0;
    endcase
  end

  assign bus.o_su_ready = (count != DEPTH_C) &&
                          (({1'b0, count} + {1'b0, outstanding}) < {1'b0, DEPTH_C});
  assign accept   = bus.i_du_valid && bus.o_su_ready;
  assign is_store = (bus.i_du_opcode == OP_STORE);
  assign enq      = accept && is_store && req_f3_ok && !(TRAP_EN && req_misaligned);

  assign head_valid       = (count != '0);
  assign bus.o_dm_awvalid = head_valid && !aw_done;
  assign bus.o_dm_wvalid  = head_valid && !w_done;
  assign bus.o_dm_awaddr  = mem_addr[rd_ptr];
  assign bus.o_dm_wdata   = mem_data[rd_ptr];
  assign bus.o_dm_wstrb   = mem_strb[rd_ptr];
  assign bus.o_dm_awprot  = '0;
  assign bus.o_dm_bready  = 1'b1;

  assign aw_fire = bus.o_dm_awvalid && bus.i_dm_awready;
  assign w_fire  = bus.o_dm_wvalid && bus.i_dm_wready;
  // Head retires when the later of its two channels completes, possibly both in one cycle.
  assign pop     = head_valid && (aw_done || aw_fire) && (w_done || w_fire);
  assign b_fire  = bus.i_dm_bvalid;
  assign b_dec   = b_fire && (outstanding != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
        mem_strb[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (enq) begin
        mem_addr[wr_ptr] <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        mem_data[wr_ptr] <= req_data;
        mem_strb[wr_ptr] <= req_strb;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (enq && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !enq) begin
        count <= count - CW'(1);
      end
      aw_done     <= pop ? 1'b0 : (aw_done || aw_fire);
      w_done      <= pop ? 1'b0 : (w_done || w_fire);
      outstanding <= outstanding + CW'(pop) - CW'(b_dec);
      err_q       <= (accept && is_store && !req_f3_ok) ||
                     (b_fire && (bus.i_dm_bresp != 2'b00));
    end
  end

  assign o_su_idle = (count == '0) && (outstanding == '0);
  assign o_su_err  = err_q;

`ifdef STORE_UNIT_MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= accept && is_store && req_f3_ok && req_misaligned;
    end
  end
  assign o_su_misalign = mis_q;
`endif
endmodule

// File: tb/tb_store_queue_unit.sv
// Randomized bench for store_queue_unit against a queue-based reference model, plus directed cases.
module tb_store_queue_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [6:0] OP_ST = 7'b0100011;
`ifdef STORE_UNIT_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic idle, err;
`ifdef STORE_UNIT_MISALIGN_TRAP_EN
  logic mis;
`endif
  always #5 clk = ~clk;

  store_queue_unit_if #(.XLEN(XLEN)) bus();

  store_queue_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .o_su_idle (idle),
    .o_su_err  (err)
`ifdef STORE_UNIT_MISALIGN_TRAP_EN
    ,
    .o_su_misalign (mis)
`endif
  );

  int n_pass = 0;
  int n_total = 0;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: pending stores as a queue of beats, plus per-head channel progress.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;
  beat_t q[$];
  bit aw_seen = 0, w_seen = 0, err_exp = 0, mis_exp = 0;
  int outst = 0;
  int err_seen = 0;
  bit stop = 0;

  function automatic bit model_ready();
    return (q.size() < DEPTH) && (q.size() + outst < DEPTH);
  endfunction

  function automatic void make_beat(input logic [2:0] f3, input logic [31:0] rs1, imm, rs2,
                                    output beat_t b, output bit ok, output bit mi);
    logic [31:0] a;
    int off, size;
    a = rs1 + imm;
    off = int'(a % 32'd4);
    ok = 1;
    size = 1;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      default: ok = 0;
    endcase
    b.addr = a - 32'(off);
    b.strb = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) b.data[8*i +: 8] = 8'(rs2 >> (8 * (i % size)));
    mi = (off % size) != 0;
  endfunction

  task automatic model_step();
    beat_t b;
    bit ok, mi, acc, pop, a, w, en, mn;
    acc = bus.i_du_valid && model_ready();
    en = 0; mn = 0; pop = 0;
    if (q.size() > 0) begin
      a = aw_seen || bus.i_dm_awready;
      w = w_seen || bus.i_dm_wready;
      if (a && w) begin
        q.delete(0); aw_seen = 0; w_seen = 0; pop = 1;
      end else begin
        aw_seen = a; w_seen = w;
      end
    end
    if (bus.i_dm_bvalid) begin
      outst--;
      if (bus.i_dm_bresp != 2'b00) en = 1;
    end
    if (pop) outst++;
    if (acc && bus.i_du_opcode == OP_ST) begin
      make_beat(bus.i_du_funct3, bus.i_du_rf_rs1_rdata, bus.i_du_immediate,
                bus.i_du_rf_rs2_rdata, b, ok, mi);
      if (!ok) en = 1;
      else if (TRAP && mi) mn = 1;
      else q.push_back(b);
    end
    err_exp = en;
    mis_exp = mn;
  endtask

  task automatic compare();
    bit hv;
    hv = q.size() > 0;
    chk("awvalid", bus.o_dm_awvalid, hv && !aw_seen);
    chk("wvalid", bus.o_dm_wvalid, hv && !w_seen);
    if (hv) begin
      chk("awaddr", bus.o_dm_awaddr, q[0].addr);
      chk("wdata", bus.o_dm_wdata, q[0].data);
      chk("wstrb", bus.o_dm_wstrb, q[0].strb);
    end
    chk("su_ready", bus.o_su_ready, model_ready());
    chk("su_idle", idle, (q.size() == 0) && (outst == 0));
    chk("su_err", err, err_exp);
    chk("bready", bus.o_dm_bready, 1);
    chk("awprot", bus.o_dm_awprot, 0);
`ifdef STORE_UNIT_MISALIGN_TRAP_EN
    chk("su_misalign", mis, mis_exp);
`endif
    if (err) err_seen++;
  endtask

  initial begin
    wait (rstn);
    while (!stop) begin
      @(negedge clk);
      compare();
      @(posedge clk);
      model_step();
    end
  end

  // Memory-side responder: random readies, one B per completed AW+W pair.
  int aw_pct = 100, w_pct = 100, b_pct = 100, b_err_pct = 0, err_b_idx = -1;
  bit b_en = 1;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;

  initial begin
    bus.i_dm_awready = 0; bus.i_dm_wready = 0; bus.i_dm_bvalid = 0; bus.i_dm_bresp = 2'b00;
    forever begin
      int pend;
      @(posedge clk); #1;
      bus.i_dm_awready = int'($urandom_range(99)) < aw_pct;
      bus.i_dm_wready  = int'($urandom_range(99)) < w_pct;
      pend = ((aw_cnt < w_cnt) ? aw_cnt : w_cnt) - b_cnt;
      if (b_en && pend > 0 && int'($urandom_range(99)) < b_pct) begin
        bus.i_dm_bvalid = 1;
        if (b_cnt == err_b_idx) bus.i_dm_bresp = 2'b10;
        else bus.i_dm_bresp = (int'($urandom_range(99)) < b_err_pct) ? 2'b10 : 2'b00;
      end else begin
        bus.i_dm_bvalid = 0;
        bus.i_dm_bresp = 2'b00;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (bus.o_dm_awvalid && bus.i_dm_awready) aw_cnt++;
      if (bus.o_dm_wvalid && bus.i_dm_wready) w_cnt++;
      if (bus.i_dm_bvalid && bus.o_dm_bready) b_cnt++;
    end
  end

  // Called at posedge+#1; returns at posedge+#1 of the accepting edge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] rs1, imm, rs2);
    bit got;
    got = 0;
    bus.i_du_valid = 1; bus.i_du_opcode = op; bus.i_du_funct3 = f3;
    bus.i_du_rf_rs1_rdata = rs1; bus.i_du_immediate = imm; bus.i_du_rf_rs2_rdata = rs2;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = bus.o_su_ready;
      @(posedge clk);
    end
    #1 bus.i_du_valid = 0;
    chk("issue_accept", got, 1);
  endtask

  task automatic wait_idle(input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = idle;
    end
    chk("drain_idle", ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_du_valid = 0; bus.i_du_opcode = '0; bus.i_du_funct3 = '0;
    bus.i_du_rf_rs1_rdata = '0; bus.i_du_immediate = '0; bus.i_du_rf_rs2_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_idle", idle, 1);
    chk("rst_ready", bus.o_su_ready, 1);
    chk("rst_awvalid", bus.o_dm_awvalid, 0);
    chk("rst_wvalid", bus.o_dm_wvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_bready", bus.o_dm_bready, 1);
    chk("rst_awaddr", bus.o_dm_awaddr, 0);
    chk("rst_wdata", bus.o_dm_wdata, 0);
    chk("rst_wstrb", bus.o_dm_wstrb, 0);
    @(posedge clk); #1 rstn = 1;

    // Single SW, readies high: one beat at the following cycle.
    issue(OP_ST, 3'b010, 32'h1000, 32'h4, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_awvalid", bus.o_dm_awvalid, 1);
    chk("sw_awaddr", bus.o_dm_awaddr, 32'h1004);
    chk("sw_wstrb", bus.o_dm_wstrb, 4'hF);
    chk("sw_wdata", bus.o_dm_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_one_beat", bus.o_dm_awvalid || bus.o_dm_wvalid, 0);
    wait_idle(50);

    issue(OP_ST, 3'b000, 32'h2003, 32'h0, 32'h000000A5);
    @(negedge clk);
    chk("sb_awaddr", bus.o_dm_awaddr, 32'h2000);
    chk("sb_wstrb", bus.o_dm_wstrb, 4'b1000);
    chk("sb_wdata", bus.o_dm_wdata, 32'hA5A5A5A5);
    wait_idle(50);

    issue(OP_ST, 3'b001, 32'h3000, 32'h1, 32'h00001234);
    @(negedge clk);
`ifdef STORE_UNIT_MISALIGN_TRAP_EN
    chk("sh_mis_pulse", mis, 1);
    chk("sh_mis_noaw", bus.o_dm_awvalid, 0);
`else
    chk("sh_mis_awaddr", bus.o_dm_awaddr, 32'h3000);
    chk("sh_mis_wstrb", bus.o_dm_wstrb, 4'b0110);
    chk("sh_mis_wdata", bus.o_dm_wdata, 32'h12341234);
`endif
    wait_idle(50);

    // W held off: AW completes alone, W holds stable payload until it is accepted.
    w_pct = 0;
    @(posedge clk); #1;
    issue(OP_ST, 3'b010, 32'h4000, 32'h8, 32'h0BADF00D);
    @(negedge clk);
    chk("bp_aw_first", bus.o_dm_awvalid, 1);
    @(negedge clk);
    chk("bp_aw_done", bus.o_dm_awvalid, 0);
    chk("bp_w_hold", bus.o_dm_wvalid, 1);
    @(negedge clk);
    chk("bp_w_hold2", bus.o_dm_wvalid, 1);
    chk("bp_w_data", bus.o_dm_wdata, 32'h0BADF00D);
    chk("bp_not_idle", idle, 0);
    w_pct = 100;
    wait_idle(50);

    // B held off: four stores fill the outstanding budget, the fifth waits for a B.
    b_en = 0;
    for (int i = 0; i < 4; i++) issue(OP_ST, 3'b010, 32'h5000, 32'(4 * i), 32'(i));
    @(negedge clk);
    chk("full_ready_low", bus.o_su_ready, 0);
    fork
      issue(OP_ST, 3'b010, 32'h5000, 32'h10, 32'h5);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("full_hold_ready", bus.o_su_ready, 0);
          chk("full_not_idle", idle, 0);
        end
        b_en = 1;
      end
    join
    wait_idle(100);

    // Error response on the second of three stores.
    err_b_idx = b_cnt + 1;
    err_seen = 0;
    for (int i = 0; i < 3; i++) issue(OP_ST, 3'b010, 32'h6000, 32'(4 * i), 32'h77);
    wait_idle(100);
    @(negedge clk); #1;
    chk("bresp_err_pulses", err_seen, 1);
    chk("bresp_idle", idle, 1);
    err_b_idx = -1;
    @(posedge clk); #1;

    b_err_pct = 10;
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [2:0] f3;
      logic [6:0] op;
      if (n % 50 == 0) begin
        aw_pct = int'($urandom_range(30, 100));
        w_pct  = int'($urandom_range(30, 100));
        b_pct  = int'($urandom_range(30, 100));
      end
      r = int'($urandom_range(9));
      f3 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      op = ($urandom_range(9) == 0) ? 7'($urandom) : OP_ST;
      issue(op, f3, $urandom, 32'($urandom_range(15)), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    aw_pct = 100; w_pct = 100; b_pct = 100; b_err_pct = 0;
    wait_idle(2000);
    stop = 1;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
